// File: rtl/inst_wb_fetch_pkg.sv
// Shared types and constants for the Wishbone instruction-fetch bridge.
package inst_wb_fetch_pkg;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_BUS  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Counter must hold TIMEOUT itself; a zero timeout still needs one bit.
    function automatic int cnt_w(int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/inst_wb_fetch_if.sv
// Wishbone B4 classic read-side bundle used by the fetch bridge.
interface inst_wb_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   adr;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [DATA_W/8-1:0] sel;
    logic [DATA_W-1:0]   dat;
    logic                ack;

    modport master (
        output adr, cyc, stb, we, sel,
        input  dat, ack
    );

    modport slave (
        input  adr, cyc, stb, we, sel,
        output dat, ack
    );
endinterface

// File: rtl/inst_wb_fetch_tmo.sv
// Saturating bus-cycle timeout counter for the fetch bridge.
module inst_wb_fetch_tmo
    import inst_wb_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = cnt_w(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/inst_wb_fetch.sv
// Instruction-fetch bridge: OpenMIPS rom port to Wishbone master,
// with a one-entry fetch buffer, flush discard and bus timeout.
module inst_wb_fetch
    import inst_wb_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    inst_wb_fetch_if.master   wb
);
    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic cyc_q, cyc_d;
    logic valid_q, valid_d;
    logic discard_q, discard_d;
    logic err_q, err_d;

    logic hit;
    logic drop;
    logic expired;
    logic tmo_clr;
    logic tmo_en;

    assign hit = rom_ce_i & valid_q & ~flush_i & (rom_addr_i == tag_q);
    assign rom_data_o = hit ? data_q : '0;
    assign stallreq_o = rom_ce_i & ~hit;
    assign bus_err_o = err_q;

    assign wb.adr = adr_q;
    assign wb.cyc = cyc_q;
    assign wb.stb = cyc_q;
    assign wb.we  = 1'b0;
    assign wb.sel = '1;

    assign tmo_clr = (state_q == FETCH_IDLE);
    assign tmo_en  = (state_q == FETCH_BUS) & ~wb.ack;

    // A flush landing on the completing cycle must still poison the result.
    assign drop = discard_q | flush_i;

    inst_wb_fetch_tmo #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(expired)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        tag_d     = tag_q;
        data_d    = data_q;
        cyc_d     = cyc_q;
        valid_d   = valid_q;
        discard_d = discard_q;
        err_d     = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                end
                if (rom_ce_i && !hit) begin
                    adr_d   = rom_addr_i;
                    cyc_d   = 1'b1;
                    state_d = FETCH_BUS;
                end
            end
            FETCH_BUS: begin
                if (wb.ack) begin
                    data_d    = wb.dat;
                    tag_d     = adr_q;
                    valid_d   = ~drop;
                    discard_d = 1'b0;
                    cyc_d     = 1'b0;
                    state_d   = FETCH_IDLE;
                end else if (expired) begin
                    data_d    = NOP_INST;
                    tag_d     = adr_q;
                    valid_d   = ~drop;
                    discard_d = 1'b0;
                    cyc_d     = 1'b0;
                    err_d     = 1'b1;
                    state_d   = FETCH_IDLE;
                end else begin
                    discard_d = drop;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_IDLE;
            adr_q     <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            cyc_q     <= 1'b0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            cyc_q     <= cyc_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_inst_wb_fetch.sv
// Scoreboarded random bench for inst_wb_fetch against a
// transaction-level model of the fetch buffer and a wait-state slave.
module tb_inst_wb_fetch;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rom_addr = '0;
    logic [31:0] rom_data;
    logic        stall;
    logic        berr;

    inst_wb_fetch_if #(.ADDR_W(32), .DATA_W(32)) wb ();

    inst_wb_fetch #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT(TMO),
        .NOP_INST(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_ce_i  (rom_ce),
        .rom_addr_i(rom_addr),
        .flush_i   (flush),
        .rom_data_o(rom_data),
        .stallreq_o(stall),
        .bus_err_o (berr),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    int slave_wait = 0;
    bit stray = 1'b0;
    int s_cnt = 0;

    logic [31:0] cur_addr = '0;
    int txn = 0;
    int errs = 0;
    int run = 0;
    int last_run = 0;
    bit cyc_prev = 1'b0;

    bit m_valid = 1'b0;
    logic [31:0] m_tag = '0;
    logic [31:0] m_data = '0;

    function automatic logic [31:0] mem(logic [31:0] a);
        if (a == 32'h0) return 32'h3401_1100;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Wishbone slave: acks `slave_wait` cycles after stb rises.
    initial begin
        wb.ack = 1'b0;
        wb.dat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wb.cyc && wb.stb) begin
                if (s_cnt >= slave_wait) begin
                    wb.ack = 1'b1;
                    wb.dat = mem(wb.adr);
                    s_cnt = 0;
                end else begin
                    wb.ack = 1'b0;
                    s_cnt++;
                end
            end else begin
                wb.ack = stray;
                wb.dat = 32'hDEAD_BEEF;
                s_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the CPU receives an instruction.
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_ce && !stall) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rom_data: unexpected %h with empty queue", rom_data);
                end else begin
                    chk("rom_data", rom_data, exp_q.pop_front());
                end
            end
            if (wb.cyc) chk("wb_adr_stable", wb.adr, cur_addr);
        end
        if (wb.cyc) begin
            run = cyc_prev ? run + 1 : 1;
            if (!cyc_prev) txn++;
        end else if (cyc_prev) begin
            last_run = run;
        end
        cyc_prev = wb.cyc;
        if (berr) errs++;
    end

    task automatic fetch(logic [31:0] a, int waits, int flush_at);
        bit hit;
        bit to;
        int n, k, es, et, ee, c, t0, e0;
        logic [31:0] ed;
        hit = m_valid && (a == m_tag) && (flush_at < 0);
        to = waits > TMO;
        n = to ? TMO : waits;
        if (hit) begin
            es = 0; et = 0; ee = 0; ed = m_data;
        end else begin
            k = (flush_at >= 1 && flush_at <= n + 1) ? 2 : 1;
            ed = to ? 32'h0 : mem(a);
            es = k * (n + 2);
            et = k;
            ee = to ? k : 0;
            m_valid = 1'b1;
            m_tag = a;
            m_data = ed;
        end
        exp_q.push_back(ed);
        t0 = txn;
        e0 = errs;
        slave_wait = waits;
        cur_addr = a;
        @(posedge clk);
        #1;
        rom_ce = 1'b1;
        rom_addr = a;
        flush = 1'b0;
        c = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            c++;
            if (c > 200) begin
                total++;
                bad++;
                $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, c);
                break;
            end
            @(posedge clk);
            #1;
            flush = (c == flush_at);
        end
        flush = 1'b0;
        #1;
        chk("stall_cycles", c, es);
        chk("wb_txn_count", txn - t0, et);
        chk("bus_err_count", errs - e0, ee);
        if (!hit) chk("cyc_len", last_run, n + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, w, n, fa;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", wb.cyc, 0);
        chk("rst_stb", wb.stb, 0);
        chk("rst_adr", wb.adr, 0);
        chk("rst_we", wb.we, 0);
        chk("rst_sel", wb.sel, 4'hF);
        chk("rst_berr", berr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_data", rom_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch(32'h0, 0, -1);
        fetch(32'h0, 0, -1);
        fetch(32'h4, 3, -1);
        fetch(32'h8, 3, 2);
        fetch(32'h8, 3, -1);
        fetch(32'hC, 1000, -1);
        fetch(32'hC, 0, -1);

        // Reset in the middle of a bus cycle, then a stray ack.
        slave_wait = 3;
        cur_addr = 32'h40;
        @(posedge clk);
        #1;
        rom_ce = 1'b1;
        rom_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstbus_cyc", wb.cyc, 0);
        chk("rstbus_stall", stall, 1);
        rom_ce = 1'b0;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        chk("stray_cyc", wb.cyc, 0);
        fetch(32'h40, 3, -1);

        // Idle CPU: no output, no stall, no bus traffic.
        @(posedge clk);
        #1;
        rom_ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_data", rom_data, 0);
            chk("idle_stall", stall, 0);
            chk("idle_cyc", wb.cyc, 0);
        end

        for (int i = 0; i < 40; i++) begin
            a = 4 * $urandom_range(0, 5);
            w = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 3);
            n = (w > TMO) ? TMO : w;
            fa = -1;
            if (!(m_valid && m_tag == a) && $urandom_range(0, 3) == 0)
                fa = $urandom_range(1, n + 1);
            fetch(a, w, fa);
        end

        @(posedge clk);
        #1;
        rom_ce = 1'b0;
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
